// File: rtl/jesd_tx_pkg.sv
// Shared constants and types for the JESD transmit link controller.
package jesd_tx_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;  // /K/ code-group sync
  localparam logic [7:0] K28_0 = 8'h1C;  // /R/ multiframe start
  localparam logic [7:0] K28_3 = 8'h7C;  // /A/ multiframe end
  localparam logic [7:0] K28_4 = 8'h9C;  // /Q/ config start

  typedef enum logic [1:0] {
    LS_CGS  = 2'd0,
    LS_ILAS = 2'd1,
    LS_DATA = 2'd2
  } link_state_t;

  typedef enum logic [1:0] {
    TP_CONST = 2'd0,
    TP_CNT   = 2'd1,
    TP_WALK  = 2'd2,
    TP_ZERO  = 2'd3
  } test_pattern_t;

  typedef struct packed {
    logic       k;
    logic [7:0] d;
  } octet_t;

  function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] s);
    logic [15:0] t;
    t = {v, v} << s;
    return t[15:8];
  endfunction

endpackage

// File: rtl/jesd_tx_testgen.sv
// Free-running cycle counter and per-lane built-in test pattern generator.
module jesd_tx_testgen
  import jesd_tx_pkg::*;
#(
  parameter int unsigned NUM_LANES = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             test_pattern,
  output logic [NUM_LANES*8-1:0] pat_c
);

  logic [7:0] cyc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 8'd1;
  end

  always_comb begin
    pat_c = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      case (test_pattern_t'(test_pattern))
        TP_CONST: pat_c[8*n +: 8] = 8'hA5 ^ 8'(n);
        TP_CNT:   pat_c[8*n +: 8] = cyc + 8'(n);
        TP_WALK:  pat_c[8*n +: 8] = rotl8(8'h01, 3'(cyc + 8'(n)));
        default:  pat_c[8*n +: 8] = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/jesd_tx_link_ctrl.sv
// Transmit link controller: CGS/ILAS/DATA sequencing per lane with LMFC
// alignment, resync detection, lane masking and a monitor tap.
module jesd_tx_link_ctrl
  import jesd_tx_pkg::*;
#(
  parameter  int unsigned NUM_LANES    = 8,
  parameter  int unsigned K_FRAMES     = 32,
  parameter  int unsigned ILAS_MF      = 4,
  parameter  int unsigned LANE_ID_BASE = 0,
  localparam int unsigned SEL_W        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sync_n,
  input  logic                   mode,
  input  logic [1:0]             test_pattern,
  input  logic [NUM_LANES-1:0]   lane_en,
  input  logic [SEL_W-1:0]       lane_sel,
  input  logic [NUM_LANES*8-1:0] data_i,
  output logic [NUM_LANES*8-1:0] lane_data,
  output logic [NUM_LANES-1:0]   lane_k,
  output logic [7:0]             mon_data,
  output logic                   mon_k,
  output logic [1:0]             link_state,
  output logic                   lmfc_pulse,
  output logic [7:0]             resync_cnt
);

  localparam int unsigned LMFC_W = $clog2(K_FRAMES);
  localparam int unsigned MF_W   = $clog2(ILAS_MF);
  localparam logic [LMFC_W-1:0] LMFC_LAST = LMFC_W'(K_FRAMES - 1);
  localparam logic [MF_W-1:0]   MF_LAST   = MF_W'(ILAS_MF - 1);

  logic                   sync_m, sync_s;
  logic [LMFC_W-1:0]      lmfc, lmfc_nxt;
  logic [MF_W-1:0]        mf, mf_nxt;
  logic [1:0]             low_run, low_run_nxt;
  logic                   resync_hit;
  link_state_t            state, state_nxt;
  logic [NUM_LANES*8-1:0] src, pat_c;
  octet_t                 ilas_oct;
  logic                   ilas_is_id;
  octet_t [NUM_LANES-1:0] oct_nxt;
  octet_t                 mon_c;

  jesd_tx_testgen #(.NUM_LANES(NUM_LANES)) u_testgen (
    .clk          (clk),
    .rst_n        (rst_n),
    .test_pattern (test_pattern),
    .pat_c        (pat_c)
  );

  // sync_n is asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_m <= 1'b0;
      sync_s <= 1'b0;
    end else begin
      sync_m <= sync_n;
      sync_s <= sync_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LS_CGS;
      lmfc       <= '0;
      mf         <= '0;
      low_run    <= '0;
      lmfc_pulse <= 1'b0;
      resync_cnt <= '0;
      src        <= '0;
    end else begin
      state      <= state_nxt;
      lmfc       <= lmfc_nxt;
      mf         <= mf_nxt;
      low_run    <= low_run_nxt;
      lmfc_pulse <= (lmfc_nxt == LMFC_LAST);
      src        <= mode ? data_i : pat_c;
      if (state == LS_DATA && state_nxt == LS_CGS && resync_cnt != 8'hFF)
        resync_cnt <= resync_cnt + 8'd1;
    end
  end

  assign link_state = state;

  // Next state and next octets share one LMFC/multiframe view so they stay aligned
  always_comb begin
    lmfc_nxt    = (lmfc == LMFC_LAST) ? '0 : lmfc + LMFC_W'(1);
    mf_nxt      = mf;
    state_nxt   = state;
    low_run_nxt = sync_s ? 2'd0 : ((low_run == 2'd3) ? 2'd3 : low_run + 2'd1);
    resync_hit  = !sync_s && (low_run == 2'd3);
    ilas_oct    = '0;
    ilas_is_id  = 1'b0;
    oct_nxt     = '0;

    case (state)
      LS_CGS: begin
        if (sync_s && lmfc == LMFC_LAST) begin
          state_nxt = LS_ILAS;
          mf_nxt    = '0;
        end
      end
      LS_ILAS: begin
        if (resync_hit) begin
          state_nxt = LS_CGS;
        end else if (lmfc == LMFC_LAST) begin
          if (mf == MF_LAST) state_nxt = LS_DATA;
          else               mf_nxt    = mf + MF_W'(1);
        end
      end
      LS_DATA: begin
        if (resync_hit) state_nxt = LS_CGS;
      end
      default: state_nxt = LS_CGS;
    endcase

    if (lmfc_nxt == '0) begin
      ilas_oct.k = 1'b1;
      ilas_oct.d = K28_0;
    end else if (lmfc_nxt == LMFC_LAST) begin
      ilas_oct.k = 1'b1;
      ilas_oct.d = K28_3;
    end else if (mf_nxt == MF_W'(1) && lmfc_nxt == LMFC_W'(1)) begin
      ilas_oct.k = 1'b1;
      ilas_oct.d = K28_4;
    end else if (mf_nxt == MF_W'(1) && lmfc_nxt == LMFC_W'(2)) begin
      ilas_is_id = 1'b1;
    end else if (mf_nxt == MF_W'(1) && lmfc_nxt == LMFC_W'(3)) begin
      ilas_oct.d = 8'(K_FRAMES - 1);
    end else begin
      ilas_oct.d = 8'(lmfc_nxt);
    end

    for (int n = 0; n < NUM_LANES; n++) begin
      if (lane_en[n]) begin
        case (state_nxt)
          LS_CGS: begin
            oct_nxt[n].k = 1'b1;
            oct_nxt[n].d = K28_5;
          end
          LS_ILAS: begin
            oct_nxt[n] = ilas_oct;
            if (ilas_is_id) oct_nxt[n].d = 8'(LANE_ID_BASE + n);
          end
          LS_DATA: oct_nxt[n].d = src[8*n +: 8];
          default: oct_nxt[n] = '0;
        endcase
      end
    end
  end

  // Reset value follows lane_en so enabled lanes come out of reset sending /K/
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_LANES; n++) begin
        lane_data[8*n +: 8] <= lane_en[n] ? K28_5 : 8'h00;
        lane_k[n]           <= lane_en[n];
      end
    end else begin
      for (int n = 0; n < NUM_LANES; n++) begin
        lane_data[8*n +: 8] <= oct_nxt[n].d;
        lane_k[n]           <= oct_nxt[n].k;
      end
    end
  end

  always_comb begin
    mon_c = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      if (lane_sel == SEL_W'(n)) begin
        mon_c.d = lane_data[8*n +: 8];
        mon_c.k = lane_k[n];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mon_data <= '0;
      mon_k    <= 1'b0;
    end else begin
      mon_data <= mon_c.d;
      mon_k    <= mon_c.k;
    end
  end

endmodule
